// File: rtl/dot_pkg.sv
// Shared types and width helpers for the round-robin dot-product arbiter.
package dot_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } dot_state_t;

    localparam int VLEN = 4;

    // Four products of 2*bits each need two extra bits so the sum cannot overflow.
    function automatic int res_width(input int bits);
        return 2 * bits + 2;
    endfunction

    function automatic int id_width(input int nreq);
        return $clog2(nreq);
    endfunction

endpackage

// File: rtl/dot4_core.sv
// Combinational 4-element unsigned dot product: four multipliers feeding a two-level adder tree.
module dot4_core
    import dot_pkg::*;
#(
    parameter int BITS = 4
) (
    input  logic [VLEN*BITS-1:0]       a,
    input  logic [VLEN*BITS-1:0]       b,
    output logic [res_width(BITS)-1:0] dot
);

    logic [2*BITS-1:0] prod [VLEN];
    logic [2*BITS:0]   sum01;
    logic [2*BITS:0]   sum23;

    always_comb begin
        for (int k = 0; k < VLEN; k++) begin
            prod[k] = {{BITS{1'b0}}, a[k*BITS +: BITS]} * {{BITS{1'b0}}, b[k*BITS +: BITS]};
        end
    end

    assign sum01 = {1'b0, prod[0]} + {1'b0, prod[1]};
    assign sum23 = {1'b0, prod[2]} + {1'b0, prod[3]};
    assign dot   = {1'b0, sum01} + {1'b0, sum23};

endmodule

// File: rtl/dot_arbiter.sv
// Round-robin scheduler sharing one dot4_core between NREQ requesters, one operation in flight.
//
// state | meaning
// IDLE  | grant the next valid requester from ptr upward; handshake captures operands
// CALC  | registered operands through dot4_core into rsp_data/rsp_id
// DONE  | rsp_valid high, result held until rsp_ready, then ptr moves past the owner
module dot_arbiter
    import dot_pkg::*;
#(
    parameter int BITS = 4,
    parameter int NREQ = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NREQ-1:0]                req_valid,
    output logic [NREQ-1:0]                req_ready,
    input  logic [NREQ*VLEN*BITS-1:0]      req_a,
    input  logic [NREQ*VLEN*BITS-1:0]      req_b,
    output logic                           rsp_valid,
    input  logic                           rsp_ready,
    output logic [res_width(BITS)-1:0]     rsp_data,
    output logic [id_width(NREQ)-1:0]      rsp_id
);

    localparam int OPW = VLEN * BITS;
    localparam int RW  = res_width(BITS);
    localparam int IDW = id_width(NREQ);

    dot_state_t       state, state_nx;
    logic [IDW-1:0]   ptr;
    logic [IDW-1:0]   gidx;
    logic             take;
    logic [OPW-1:0]   op_a, op_b;
    logic [IDW-1:0]   op_id;
    logic [RW-1:0]    dot;

    function automatic logic [IDW-1:0] rr_pick(input logic [NREQ-1:0] v, input logic [IDW-1:0] p);
        logic [IDW-1:0]  pick;
        logic [NREQ-1:0] sh;
        logic            hit;
        int              idx;
        pick = p;
        hit  = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            idx = int'(p) + i;
            if (idx >= NREQ) idx = idx - NREQ;
            sh = v >> idx;
            if (!hit && sh[0]) begin
                pick = IDW'(idx);
                hit  = 1'b1;
            end
        end
        return pick;
    endfunction

    assign gidx = rr_pick(req_valid, ptr);

    always_comb begin
        state_nx  = state;
        req_ready = '0;
        rsp_valid = 1'b0;
        take      = 1'b0;
        unique case (state)
            IDLE: begin
                // Held in reset the block must not advertise an accept to anyone.
                if ((|req_valid) && rst_n) begin
                    req_ready = NREQ'(1) << gidx;
                    take      = 1'b1;
                    state_nx  = CALC;
                end
            end
            CALC: state_nx = DONE;
            DONE: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr      <= '0;
            op_a     <= '0;
            op_b     <= '0;
            op_id    <= '0;
            rsp_data <= '0;
            rsp_id   <= '0;
        end else begin
            if (take) begin
                op_a  <= req_a[gidx*OPW +: OPW];
                op_b  <= req_b[gidx*OPW +: OPW];
                op_id <= gidx;
            end
            if (state == CALC) begin
                rsp_data <= dot;
                rsp_id   <= op_id;
            end
            if (state == DONE && rsp_ready) begin
                ptr <= (rsp_id == IDW'(NREQ - 1)) ? '0 : rsp_id + IDW'(1);
            end
        end
    end

    dot4_core #(.BITS(BITS)) u_core (
        .a   (op_a),
        .b   (op_b),
        .dot (dot)
    );

endmodule

// File: tb/tb_dot_arbiter.sv
// Directed bench for dot_arbiter: hand-computed results, grant order, backpressure and reset abort.
module tb_dot_arbiter;

    localparam int BITS = 4;
    localparam int NREQ = 4;
    localparam int OPW  = 4 * BITS;

    logic                  clk;
    logic                  rst_n;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*OPW-1:0]   req_a;
    logic [NREQ*OPW-1:0]   req_b;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [2*BITS+1:0]     rsp_data;
    logic [1:0]            rsp_id;

    int n_vec = 0;
    int n_err = 0;

    dot_arbiter #(.BITS(BITS), .NREQ(NREQ)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [OPW-1:0] pack4(input int e0, input int e1, input int e2, input int e3);
        logic [31:0] v0, v1, v2, v3;
        v0 = e0; v1 = e1; v2 = e2; v3 = e3;
        return {v3[3:0], v2[3:0], v1[3:0], v0[3:0]};
    endfunction

    task automatic set_req(input int i, input logic v, input logic [OPW-1:0] a, input logic [OPW-1:0] b);
        req_valid[i]        = v;
        req_a[i*OPW +: OPW] = a;
        req_b[i*OPW +: OPW] = b;
    endtask

    task automatic reset_dut();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_req_ready", 32'(req_ready), 0);
        chk("rst_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_rsp_data",  32'(rsp_data), 0);
        chk("rst_rsp_id",    32'(rsp_id), 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    // Called shortly after a falling edge; returns the granted index and idle cycles waited.
    task automatic wait_grant(output int g, output int waited);
        g      = -1;
        waited = -1;
        for (int c = 0; c < 20; c++) begin
            if ((req_ready & req_valid) != '0) begin
                for (int i = 0; i < NREQ; i++) if (req_ready[i]) g = i;
                waited = c;
                chk("grant_onehot", $countones(req_ready), 1);
                return;
            end
            @(negedge clk);
            #1;
        end
        chk("grant_seen", 32'(|(req_ready & req_valid)), 1);
    endtask

    // Follows a grant: one CALC cycle, then the response in DONE.
    task automatic expect_rsp(input int exp_id, input int exp_data);
        @(negedge clk);
        #1;
        chk("calc_rsp_valid", 32'(rsp_valid), 0);
        chk("calc_req_ready", 32'(req_ready), 0);
        @(negedge clk);
        #1;
        chk("done_rsp_valid", 32'(rsp_valid), 1);
        chk("done_rsp_data",  32'(rsp_data), exp_data);
        chk("done_rsp_id",    32'(rsp_id), exp_id);
    endtask

    int g, w;
    int exp_order [4];

    initial begin
        rst_n     = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b0;

        // Basic result, one-cycle rsp_valid pulse
        reset_dut();
        chk("idle_no_valid_ready", 32'(req_ready), 0);
        rsp_ready = 1'b1;
        set_req(0, 1'b1, pack4(1, 2, 3, 4), pack4(5, 6, 7, 8));
        #1;
        wait_grant(g, w);
        chk("basic_id", g, 0);
        chk("basic_wait", w, 0);
        expect_rsp(0, 70);
        set_req(0, 1'b0, '0, '0);
        @(negedge clk);
        #1;
        chk("basic_pulse_end", 32'(rsp_valid), 0);

        // Width boundary: all 15 then all 0
        set_req(3, 1'b1, pack4(15, 15, 15, 15), pack4(15, 15, 15, 15));
        #1;
        wait_grant(g, w);
        chk("max_id", g, 3);
        expect_rsp(3, 900);
        set_req(3, 1'b0, '0, '0);
        set_req(2, 1'b1, pack4(0, 0, 0, 0), pack4(0, 0, 0, 0));
        @(negedge clk);
        #1;
        wait_grant(g, w);
        chk("zero_id", g, 2);
        expect_rsp(2, 0);
        set_req(2, 1'b0, '0, '0);

        // Contention between 0 and 2
        reset_dut();
        set_req(0, 1'b1, pack4(1, 1, 1, 1), pack4(1, 1, 1, 1));
        set_req(2, 1'b1, pack4(1, 2, 3, 4), pack4(4, 3, 2, 1));
        exp_order = '{0, 2, 0, 2};
        #1;
        for (int k = 0; k < 4; k++) begin
            wait_grant(g, w);
            chk("cont_order", g, exp_order[k]);
            chk("cont_wait", w, 0);
            expect_rsp(exp_order[k], (exp_order[k] == 0) ? 4 : 20);
            if (k == 3) req_valid = '0;
            @(negedge clk);
            #1;
        end
        chk("cont_idle_quiet", 32'(req_ready), 0);

        // Pointer wrap with requesters 1 and 3
        reset_dut();
        set_req(1, 1'b1, pack4(3, 0, 0, 0), pack4(5, 0, 0, 0));
        set_req(3, 1'b1, pack4(0, 0, 0, 7), pack4(0, 0, 0, 9));
        exp_order = '{1, 3, 1, 3};
        #1;
        for (int k = 0; k < 3; k++) begin
            wait_grant(g, w);
            chk("wrap_order", g, exp_order[k]);
            expect_rsp(exp_order[k], (exp_order[k] == 1) ? 15 : 63);
            @(negedge clk);
            #1;
        end

        // Backpressure on requester 3's result
        wait_grant(g, w);
        chk("bp_id", g, 3);
        rsp_ready = 1'b0;
        expect_rsp(3, 63);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            #1;
            chk("bp_rsp_valid", 32'(rsp_valid), 1);
            chk("bp_rsp_data",  32'(rsp_data), 63);
            chk("bp_rsp_id",    32'(rsp_id), 3);
            chk("bp_req_ready", 32'(req_ready), 0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        #1;
        wait_grant(g, w);
        chk("bp_release_id", g, 1);
        chk("bp_release_wait", w, 0);

        // Reset during CALC discards requester 1's operation
        @(negedge clk);
        #1;
        chk("abort_in_calc", 32'(rsp_valid), 0);
        rst_n = 1'b0;
        #1;
        chk("abort_req_ready", 32'(req_ready), 0);
        chk("abort_rsp_valid", 32'(rsp_valid), 0);
        chk("abort_rsp_data",  32'(rsp_data), 0);
        chk("abort_rsp_id",    32'(rsp_id), 0);
        set_req(1, 1'b1, pack4(2, 0, 0, 0), pack4(2, 0, 0, 0));
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("abort_no_rsp", 32'(rsp_valid), 0);
        wait_grant(g, w);
        chk("abort_first_grant", g, 1);
        chk("abort_grant_wait", w, 0);
        expect_rsp(1, 4);
        req_valid = '0;
        @(negedge clk);
        #1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
